// File: rtl/mux_src_arbiter_pkg.sv
// Shared state encodings and mux select constants for the source arbiter.
package mux_src_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_src_arbiter_arb_rr_pick.sv
// Combinational grant picker for the two mux sources.
// Define MUX_ARB_FIXED_PRIO_EN for fixed A-over-B priority; default is round-robin on `last`.
module arb_rr_pick
    import mux_src_arbiter_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic last,
    output logic grant_valid,
    output logic grant_sel
);

    always_comb begin
        grant_valid = a_valid | b_valid;
        grant_sel   = SEL_A;
`ifdef MUX_ARB_FIXED_PRIO_EN
        if (!a_valid && b_valid) begin
            grant_sel = SEL_B;
        end
`else
        // On a tie the source that was not served last wins.
        if (a_valid && b_valid) begin
            grant_sel = (last == SEL_A) ? SEL_B : SEL_A;
        end else if (b_valid) begin
            grant_sel = SEL_B;
        end
`endif
    end

`ifdef MUX_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/mux_src_arbiter.sv
// Arbitrates sources A/B onto the 2:1 mux, captures the mux output and hands it
// downstream over valid/ready. Grant policy selected by MUX_ARB_FIXED_PRIO_EN (see arb_rr_pick).
module mux_src_arbiter
    import mux_src_arbiter_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    output logic         a_ack,
    input  logic         b_valid,
    output logic         b_ack,
    output logic         sel,
    input  logic [W-1:0] y_in,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    state_e         state_q, state_d;
    logic           sel_q, sel_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           a_ack_q, a_ack_d;
    logic           b_ack_q, b_ack_d;
    logic           last_q, last_d;
    logic           grant_valid;
    logic           grant_sel;

    // A source whose ack is showing this cycle is not a new request yet.
    arb_rr_pick u_pick (
        .a_valid     (a_valid & ~a_ack_q),
        .b_valid     (b_valid & ~b_ack_q),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d     = state_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        last_d      = last_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    sel_d   = grant_sel;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                out_data_d  = y_in;
                out_valid_d = 1'b1;
                a_ack_d     = (sel_q == SEL_A);
                b_ack_d     = (sel_q == SEL_B);
                last_d      = sel_q;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (grant_valid) begin
                        sel_d   = grant_sel;
                        state_d = ST_SEL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_A;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            last_q      <= SEL_B;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            last_q      <= last_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Randomized scoreboard bench for mux_src_arbiter; the expected grant timeline is
// predicted from the arbitration rules and checked by an independent monitor.
module tb_mux_src_arbiter;

    logic       clk;
    logic       rst;
    logic       a_valid, a_ack;
    logic       b_valid, b_ack;
    logic       sel;
    logic [1:0] y_in;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    logic [1:0] a_data, b_data;

    mux_src_arbiter #(.W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ack     (a_ack),
        .b_valid   (b_valid),
        .b_ack     (b_ack),
        .sel       (sel),
        .y_in      (y_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // External 2:1 mux being controlled.
    assign y_in = sel ? b_data : a_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc_cnt);
        end
    endtask

    // Expected capture event: ack cycle, granted source (0=A, 1=B), captured word.
    typedef struct {
        int         cyc;
        logic       src;
        logic [1:0] data;
    } exp_t;

    exp_t exp_q[$];

    // Reference timeline: a grant decided at cycle g shows sel at g+1 and the
    // captured word plus ack at g+2; the next decision waits for the first
    // out_ready at or after g+2.
    bit   m_idle = 1'b1;
    int   m_gcyc = 0;
    logic m_gsrc = 1'b0;
    logic m_last = 1'b1;

    task automatic model_reset();
        exp_q.delete();
        m_idle = 1'b1;
        m_last = 1'b1;
    endtask

    task automatic model_grant(input logic va, input logic vb);
        exp_t e;
        logic w;
`ifdef MUX_ARB_FIXED_PRIO_EN
        w = !va;
`else
        w = (va && vb) ? !m_last : !va;
`endif
        e.cyc  = cyc_cnt + 2;
        e.src  = w;
        e.data = w ? b_data : a_data;
        exp_q.push_back(e);
        m_idle = 1'b0;
        m_gcyc = cyc_cnt;
        m_gsrc = w;
        m_last = w;
    endtask

    task automatic model_eval();
        logic va, vb;
        va = a_valid;
        vb = b_valid;
        if (m_idle) begin
            if (va || vb) model_grant(va, vb);
        end else if (cyc_cnt >= m_gcyc + 2 && out_ready) begin
            if (cyc_cnt == m_gcyc + 2) begin
                if (m_gsrc) vb = 1'b0;
                else        va = 1'b0;
            end
            if (va || vb) model_grant(va, vb);
            else          m_idle = 1'b1;
        end
    endtask

    // Stimulus policy knobs.
    int         a_rate = 0, b_rate = 0, ready_rate = 100;
    bit         a_fixed = 1'b0, b_fixed = 1'b0;
    logic [1:0] a_fix = 2'b00, b_fix = 2'b00;
    int         rst_cycles = 0;
    bit         sel_rst_arm = 1'b0;
    bit         sel_rst_hit = 1'b0;

    task automatic check_reset_vals();
        check("rst_sel",       sel,       1'b0);
        check("rst_out_data",  out_data,  2'b00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_a_ack",     a_ack,     1'b0);
        check("rst_b_ack",     b_ack,     1'b0);
        check("rst_busy",      busy,      1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) check_reset_vals();
        if (rst_cycles > 0) begin
            rst = 1'b1;
            rst_cycles--;
        end else begin
            rst = 1'b0;
        end
        // Sources hold their word until acked, then may offer a new one.
        if (a_ack) a_valid = 1'b0;
        if (!a_valid && $urandom_range(99, 0) < a_rate) begin
            a_valid = 1'b1;
            a_data  = a_fixed ? a_fix : 2'($urandom_range(3, 0));
        end
        if (b_ack) b_valid = 1'b0;
        if (!b_valid && $urandom_range(99, 0) < b_rate) begin
            b_valid = 1'b1;
            b_data  = b_fixed ? b_fix : 2'($urandom_range(3, 0));
        end
        out_ready = ($urandom_range(99, 0) < ready_rate);
        if (sel_rst_arm && !m_idle && cyc_cnt == m_gcyc + 1) begin
            rst         = 1'b1;
            sel_rst_arm = 1'b0;
            sel_rst_hit = 1'b1;
        end
        if (rst) model_reset();
        else     model_eval();
    endtask

    // Monitor: compares DUT behaviour against the expected timeline.
    bit         hold_prev = 1'b0;
    logic [1:0] hold_data = 2'b00;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_out_valid", out_valid, 1'b1);
                check("hold_out_data",  out_data,  hold_data);
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;

            if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt + 1) begin
                check("sel_before_capture", sel, exp_q[0].src);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
                check("a_ack",     a_ack,     exp_q[0].src == 1'b0);
                check("b_ack",     b_ack,     exp_q[0].src == 1'b1);
                check("out_valid", out_valid, 1'b1);
                check("out_data",  out_data,  exp_q[0].data);
                void'(exp_q.pop_front());
            end else if (a_ack || b_ack) begin
                check("spurious_ack", {a_ack, b_ack}, 2'b00);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        rst_cycles = 1;
        a_valid    = 1'b1;
        a_data     = 2'b10;
        b_valid    = 1'b0;
        b_data     = 2'b00;
        out_ready  = 1'b1;

        // Reset held two cycles with A requesting, then a single A transfer.
        repeat (8) step();

        // Tie: both always requesting, fixed words, downstream always ready.
        a_fixed = 1'b1; a_fix = 2'b01; a_rate = 100;
        b_fixed = 1'b1; b_fix = 2'b11; b_rate = 100;
        ready_rate = 100;
        repeat (12) step();

        // Drain, then B-only traffic with backpressure after capturing 2'b11.
        a_rate = 0; b_rate = 0;
        repeat (8) step();
        b_rate = 100;
        ready_rate = 0;
        repeat (9) step();
        ready_rate = 100;
        repeat (4) step();

        // Reset asserted in a SEL cycle.
        a_fixed = 1'b0; b_fixed = 1'b0;
        a_rate = 60; b_rate = 60;
        sel_rst_arm = 1'b1;
        repeat (30) step();

        // Random traffic with random backpressure.
        a_rate = 50; b_rate = 50; ready_rate = 70;
        repeat (400) step();

        // Final drain.
        a_rate = 0; b_rate = 0; ready_rate = 100;
        repeat (12) step();

        check("drain_empty", exp_q.size(), 0);
        check("rst_in_sel_reached", sel_rst_hit, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
